// File: rtl/cpu_pkg.sv
// Shared types for the control unit: opcodes, FSM state encodings and ALU selects.
// state_e values are fixed because they are exported on state_o for debug.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'h0,
        OP_STORE = 4'h1,
        OP_LOAD  = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_HALT  = 4'h5
    } opcode_e;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_e;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    // Unassigned opcodes fall through to NOOP.
    function automatic state_e exec_state(input logic [3:0] op);
        case (op)
            OP_STORE: return ST_STORE;
            OP_LOAD:  return ST_LOAD_A;
            OP_ADD:   return ST_ADD;
            OP_SUB:   return ST_SUB;
            OP_HALT:  return ST_HALT;
            default:  return ST_NOOP;
        endcase
    endfunction

endpackage

// File: rtl/program_counter.sv
// 7-bit program counter with synchronous clear and increment; wraps 127 -> 0.
module program_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [6:0] pc_o
);

    logic [6:0] pc_q;
    logic [6:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clr_i) begin
            pc_d = '0;
        end else if (inc_i) begin
            pc_d = pc_q + 7'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetches 16-bit instructions into IR and sequences
// register file, data memory and ALU strobes one FSM state per clock.
module control_unit
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] instr,
    output logic [6:0]  pc_addr,
    output logic        ir_ld,
    output logic [7:0]  d_addr,
    output logic        d_wr,
    output logic        rf_s,
    output logic [3:0]  rf_w_addr,
    output logic        rf_w_en,
    output logic [3:0]  rf_ra_addr,
    output logic [3:0]  rf_rb_addr,
    output logic [2:0]  alu_s,
    output logic [3:0]  state_o
);

    state_e      state_q;
    state_e      state_d;
    logic [15:0] ir_q;
    logic [15:0] ir_d;

    program_counter u_pc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (state_q == ST_INIT),
        .inc_i   (state_q == ST_FETCH),
        .pc_o    (pc_addr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH: begin
                ir_d    = instr;
                state_d = ST_DECODE;
            end
            ST_DECODE: state_d = exec_state(ir_q[15:12]);
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_NOOP, ST_LOAD_B, ST_STORE, ST_ADD, ST_SUB: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_INIT;
        endcase
    end

    // Addresses are zeroed outside the states that use them so idle cycles are clean.
    always_comb begin
        ir_ld      = 1'b0;
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_w_addr  = '0;
        rf_w_en    = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_s      = ALU_PASS;
        case (state_q)
            ST_FETCH:  ir_ld = 1'b1;
            ST_LOAD_A: begin
                d_addr = ir_q[11:4];
                rf_s   = 1'b1;
            end
            ST_LOAD_B: begin
                d_addr    = ir_q[11:4];
                rf_s      = 1'b1;
                rf_w_addr = ir_q[3:0];
                rf_w_en   = 1'b1;
            end
            ST_STORE: begin
                d_addr     = ir_q[7:0];
                rf_ra_addr = ir_q[11:8];
                d_wr       = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                rf_ra_addr = ir_q[11:8];
                rf_rb_addr = ir_q[7:4];
                rf_w_addr  = ir_q[3:0];
                rf_w_en    = 1'b1;
                alu_s      = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: an instruction-level model expands each
// fetched word into its expected per-cycle output trace and compares every cycle.
module tb_control_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] instr;
    logic [6:0]  pc_addr;
    logic        ir_ld;
    logic [7:0]  d_addr;
    logic        d_wr;
    logic        rf_s;
    logic [3:0]  rf_w_addr;
    logic        rf_w_en;
    logic [3:0]  rf_ra_addr;
    logic [3:0]  rf_rb_addr;
    logic [2:0]  alu_s;
    logic [3:0]  state_o;

    control_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .instr      (instr),
        .pc_addr    (pc_addr),
        .ir_ld      (ir_ld),
        .d_addr     (d_addr),
        .d_wr       (d_wr),
        .rf_s       (rf_s),
        .rf_w_addr  (rf_w_addr),
        .rf_w_en    (rf_w_en),
        .rf_ra_addr (rf_ra_addr),
        .rf_rb_addr (rf_rb_addr),
        .alu_s      (alu_s),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    // Instruction memory.
    logic [15:0] imem [128];
    assign instr = imem[pc_addr];

    typedef struct packed {
        logic [3:0] st;
        logic [6:0] pc;
        logic       ir_ld;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] wa;
        logic       we;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
    } obs_t;

    int   n_cmp = 0;
    int   n_err = 0;
    obs_t exp_q[$];
    logic [6:0] model_pc;
    bit   model_halted;

    function automatic obs_t observe();
        obs_t o;
        o.st = state_o; o.pc = pc_addr; o.ir_ld = ir_ld; o.d_addr = d_addr;
        o.d_wr = d_wr; o.rf_s = rf_s; o.wa = rf_w_addr; o.we = rf_w_en;
        o.ra = rf_ra_addr; o.rb = rf_rb_addr; o.alu = alu_s;
        return o;
    endfunction

    function automatic obs_t blank(input state_e s, input logic [6:0] pc);
        obs_t o;
        o = '0;
        o.st = s;
        o.pc = pc;
        return o;
    endfunction

    // Expand the next instruction into its expected cycle-by-cycle outputs.
    task automatic push_next();
        obs_t e;
        logic [15:0] w;
        if (model_halted) begin
            exp_q.push_back(blank(ST_HALT, model_pc));
            return;
        end
        w = imem[model_pc];
        $display("instr pc=%0d word=%h", model_pc, w);
        e = blank(ST_FETCH, model_pc);
        e.ir_ld = 1'b1;
        exp_q.push_back(e);
        model_pc = model_pc + 7'd1;
        exp_q.push_back(blank(ST_DECODE, model_pc));
        case (w[15:12])
            4'h1: begin
                e = blank(ST_STORE, model_pc);
                e.d_addr = w[7:0]; e.ra = w[11:8]; e.d_wr = 1'b1;
                exp_q.push_back(e);
            end
            4'h2: begin
                e = blank(ST_LOAD_A, model_pc);
                e.d_addr = w[11:4]; e.rf_s = 1'b1;
                exp_q.push_back(e);
                e.st = ST_LOAD_B; e.we = 1'b1; e.wa = w[3:0];
                exp_q.push_back(e);
            end
            4'h3, 4'h4: begin
                e = blank((w[15:12] == 4'h3) ? ST_ADD : ST_SUB, model_pc);
                e.ra = w[11:8]; e.rb = w[7:4]; e.wa = w[3:0]; e.we = 1'b1;
                e.alu = (w[15:12] == 4'h3) ? 3'b001 : 3'b010;
                exp_q.push_back(e);
            end
            4'h5: begin
                exp_q.push_back(blank(ST_HALT, model_pc));
                model_halted = 1'b1;
            end
            default: exp_q.push_back(blank(ST_NOOP, model_pc));
        endcase
    endtask

    task automatic run_cycles(input int n, input string tag);
        obs_t e;
        obs_t o;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) push_next();
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL %s cycle %0d: got %h required %h", tag, i, o, e);
            end
            n_cmp++;
            if ((d_wr & rf_w_en) !== 1'b0) begin
                n_err++;
                $display("FAIL %s cycle %0d exclusive strobes: d_wr=%b rf_w_en=%b required not both 1",
                         tag, i, d_wr, rf_w_en);
            end
        end
    endtask

    task automatic fill_imem(input logic [15:0] w);
        for (int i = 0; i < 128; i++) imem[i] = w;
    endtask

    task automatic apply_reset(input string tag);
        obs_t o;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_pc = '0;
        model_halted = 1'b0;
        exp_q.delete();
        #1;
        o = observe();
        n_cmp++;
        if (o !== blank(ST_INIT, 7'd0)) begin
            n_err++;
            $display("FAIL %s post-reset: got %h required %h", tag, o, blank(ST_INIT, 7'd0));
        end
    endtask

    task automatic test_reset();
        obs_t o;
        fill_imem(16'h0000);
        apply_reset("reset");
        run_cycles(7, "reset_run");
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 o = observe();
        n_cmp++;
        if (o !== blank(ST_INIT, 7'd0)) begin
            n_err++;
            $display("FAIL async_reset: got %h required %h", o, blank(ST_INIT, 7'd0));
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 o = observe();
            n_cmp++;
            if (o !== blank(ST_INIT, 7'd0)) begin
                n_err++;
                $display("FAIL reset_hold %0d: got %h required %h", i, o, blank(ST_INIT, 7'd0));
            end
        end
        apply_reset("reset_release");
        run_cycles(4, "reset_first_fetch");
    endtask

    task automatic test_halt();
        fill_imem(16'h0000);
        imem[0] = 16'h5000;
        apply_reset("halt");
        run_cycles(23, "halt");
        n_cmp++;
        if (pc_addr !== 7'd1) begin
            n_err++;
            $display("FAIL halt_pc: got %0d required 1", pc_addr);
        end
    endtask

    task automatic test_load_store();
        fill_imem(16'h0000);
        imem[0] = 16'h2053;
        imem[1] = 16'h1A22;
        imem[2] = 16'h5000;
        apply_reset("load_store");
        run_cycles(12, "load_store");
    endtask

    task automatic test_add_sub();
        fill_imem(16'h0000);
        imem[0] = 16'h3121;
        imem[1] = 16'h4121;
        imem[2] = 16'h5000;
        apply_reset("add_sub");
        run_cycles(12, "add_sub");
    endtask

    // Abort a write-strobe state with an asynchronous reset between clock edges.
    task automatic abort_in(input logic [15:0] w, input int pre, input string tag);
        obs_t o;
        fill_imem(16'h0000);
        imem[0] = w;
        apply_reset(tag);
        run_cycles(pre, tag);
        @(posedge clk);
        #1;
        n_cmp++;
        if ((rf_w_en | d_wr) !== 1'b1) begin
            n_err++;
            $display("FAIL %s pre-abort strobe: got we=%b wr=%b required one set", tag, rf_w_en, d_wr);
        end
        #2 reset_n = 1'b0;
        #1 o = observe();
        n_cmp++;
        if (o !== blank(ST_INIT, 7'd0)) begin
            n_err++;
            $display("FAIL %s abort: got %h required %h", tag, o, blank(ST_INIT, 7'd0));
        end
        apply_reset(tag);
    endtask

    task automatic test_back_to_back_wrap();
        fill_imem(16'h0000);
        imem[5]   = 16'hF000;
        imem[64]  = 16'h7ABC;
        imem[127] = 16'hF123;
        apply_reset("wrap");
        run_cycles(3 * 128 + 9, "wrap");
    endtask

    task automatic test_random(input int rounds);
        logic [15:0] w;
        for (int r = 0; r < rounds; r++) begin
            for (int i = 0; i < 128; i++) begin
                w = 16'($urandom);
                if (w[15:12] == 4'h5 && $urandom_range(0, 7) != 0) w[15:12] = 4'h3;
                imem[i] = w;
            end
            apply_reset("random");
            run_cycles(300, "random");
        end
    endtask

    initial begin
        reset_n = 1'b0;
        fill_imem(16'h0000);
        test_reset();
        test_halt();
        test_load_store();
        test_add_sub();
        abort_in(16'h2053, 3, "abort_load_b");
        abort_in(16'h1A22, 2, "abort_store");
        test_back_to_back_wrap();
        test_random(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
